// File: rtl/game_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// game_pkg : shared state codes, LFSR seed and width-mask helper for the game
// Rev 1.0
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GREET   = 3'd1,
    ST_COUNT   = 3'd2,
    ST_PLAY    = 3'd3,
    ST_JUDGE   = 3'd4,
    ST_VICTORY = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Low `width` bits set, saturating at 8.
  function automatic logic [7:0] level_mask(input int width);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lfsr8 : free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, loads seed on reset
// Rev 1.0
// -----------------------------------------------------------------------------
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule
`default_nettype wire

// File: rtl/guess_game_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// guess_game_ctrl : multi-level guessing game with countdown and LFSR target.
// Define GUESS_HINT_EN to add the hint[1:0] output. Rev 1.0
// -----------------------------------------------------------------------------
module guess_game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int BASE_WIDTH = 5,
  parameter int TICK_DIV   = 50_000_000,
  parameter int COUNTDOWN  = 3,
  parameter int MAX_TRIES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] guess,
  output logic [2:0] state_o,
  output logic [1:0] level_o,
  output logic [3:0] count_o,
  output logic [2:0] tries_o,
  output logic [7:0] secret_o,
  output logic       beep,
  output logic       win,
  output logic       fail
`ifdef GUESS_HINT_EN
  ,
  output logic [1:0] hint
`endif
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state, state_nx;
  logic [7:0]       lfsr_q;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       cur_mask, guess_m;
  logic [1:0]       level_nx;
  logic             tick, match, last_try, last_level, enter_count;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign cur_mask    = level_mask(BASE_WIDTH + int'(level_o));
  assign guess_m     = guess & cur_mask;
  assign match       = (guess_m == secret_o);
  assign last_try    = (int'(tries_o) + 1 == MAX_TRIES);
  assign last_level  = (int'(level_o) == NUM_LEVELS - 1);
  assign tick        = (div_cnt == DIV_LAST);
  assign enter_count = (state_nx == ST_COUNT) && (state != ST_COUNT);
  // Only a correct judge advances the level; every other COUNT entry restarts at 0.
  assign level_nx    = (state == ST_JUDGE) ? level_o + 2'd1 : 2'd0;
  assign state_o     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:                       state_nx = ST_GREET;
        ST_GREET, ST_VICTORY, ST_FAIL: if (start) state_nx = ST_COUNT;
        ST_COUNT: begin
          if (count_o == 4'd0 || (tick && count_o == 4'd1)) state_nx = ST_PLAY;
        end
        ST_PLAY: begin
          if (start)       state_nx = ST_COUNT;
          else if (submit) state_nx = ST_JUDGE;
        end
        ST_JUDGE: begin
          if (match) state_nx = last_level ? ST_VICTORY : ST_COUNT;
          else       state_nx = last_try   ? ST_FAIL    : ST_PLAY;
        end
        default:                       state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_o  <= '0;
      count_o  <= '0;
      tries_o  <= '0;
      secret_o <= '0;
      div_cnt  <= '0;
      beep     <= 1'b0;
      win      <= 1'b0;
      fail     <= 1'b0;
    end else begin
      beep <= (state_nx == ST_JUDGE);
      win  <= (state_nx == ST_VICTORY);
      fail <= (state_nx == ST_FAIL);
      if (state_nx == ST_IDLE) begin
        level_o  <= '0;
        count_o  <= '0;
        tries_o  <= '0;
        secret_o <= '0;
        div_cnt  <= '0;
      end else if (enter_count) begin
        level_o  <= level_nx;
        tries_o  <= '0;
        count_o  <= 4'(COUNTDOWN);
        div_cnt  <= '0;
        secret_o <= lfsr_q & level_mask(BASE_WIDTH + int'(level_nx));
      end else if (state == ST_COUNT) begin
        if (state_nx != ST_COUNT) begin
          count_o <= '0;
          div_cnt <= '0;
        end else if (tick) begin
          count_o <= count_o - 4'd1;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else if (state == ST_JUDGE) begin
        tries_o <= match ? 3'd0 : tries_o + 3'd1;
      end
    end
  end

`ifdef GUESS_HINT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hint <= 2'b00;
    end else if (state_nx == ST_IDLE || enter_count) begin
      hint <= 2'b00;
    end else if (state == ST_JUDGE) begin
      if (guess_m < secret_o)      hint <= 2'b01;
      else if (guess_m > secret_o) hint <= 2'b10;
      else                         hint <= 2'b00;
    end
  end
`endif

endmodule
`default_nettype wire
